ram_read_stream: RTL and testbench

Reader-side companion to the RAM write controller. On a start pulse it sweeps an address range of the 256x8 single-port RAM (my_ram) and reads each byte. It presents each byte on a valid/ready byte stream to the UART transmit path, so RAM contents can be dumped over the DE2-115 UART. During a sweep it owns the RAM address port, and the write side holds wren low.

---
 rtl/ram_read_stream.sv | 119 +++++++++++
 tb/tb_ram_read_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_stream.sv
`default_nettype none
// ============================================================================
// ram_read_stream: sweeps a RAM address range and streams each byte out over
// a valid/ready interface. Revision 1.0
// ============================================================================
module ram_read_stream #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] C_LAT = CNT_W'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = first_addr;
          last_d  = last_addr;
          cnt_d   = C_LAT;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // One extra edge after the count expires lets q settle for the new address.
        if (cnt_q == '0) begin
          tx_data_d  = ram_q;
          tx_valid_d = 1'b1;
          state_d    = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (addr_q == last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = C_LAT;
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ram_addr = addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_read_stream.sv
`default_nettype none
// ============================================================================
// tb_ram_read_stream: scoreboard bench for ram_read_stream with a 256x8 RAM
// model preloaded with mem[a] = a ^ 8'h5A. Revision 1.0
// ============================================================================
module tb_ram_read_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] first_addr = '0;
  logic [7:0] last_addr = '0;
  logic [7:0] ram_addr;
  logic [7:0] ram_q = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem[256];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_rx = 0;
  int         n_done = 0;
  int         exp_done = 0;
  int         cyc = 0;

  ram_read_stream #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .ram_addr(ram_addr), .ram_q(ram_q),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference: a sweep yields ((last-first) mod 256)+1 bytes of mem, wrapping.
  task automatic push_sweep(input logic [7:0] f, input logic [7:0] l);
    int n;
    logic [7:0] a;
    n = (((int'(l) - int'(f)) % 256 + 256) % 256) + 1;
    for (int i = 0; i < n; i++) begin
      a = 8'((int'(f) + i) % 256);
      exp_q.push_back('{addr: a, data: a ^ 8'h5A});
    end
    exp_done++;
  endtask

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic start_sweep(input logic [7:0] f, input logic [7:0] l, input bit accept);
    start = 1'b1;
    first_addr = f;
    last_addr = l;
    if (accept) push_sweep(f, l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_ready);
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < budget) begin
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    check("sweep_completed", (busy || exp_q.size() != 0) ? 32'd0 : 32'd1, 32'd1);
    tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!tx_valid && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("valid_seen", 32'(tx_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      exp_t e;
      n_rx++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: actual %0h required none", tx_data);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.data));
        check("ram_addr", 32'(ram_addr), 32'(e.addr));
      end
    end
    if (done) begin
      n_done++;
      check("busy_low_with_done", 32'(busy), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int cnt;
    int k;
    int rx0;
    logic [7:0] f;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;

    // 1: reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_ram_addr", 32'(ram_addr), 32'd0);
      check("idle_tx_valid", 32'(tx_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_tx_data", 32'(tx_data), 32'd0);
    end

    // 2: single byte timing
    tx_ready = 1'b1;
    start_sweep(8'h10, 8'h10, 1'b1);
    @(posedge clk); #1;
    check("single_valid_e1", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    check("single_valid_e2", 32'(tx_valid), 32'd1);
    check("single_data", 32'(tx_data), 32'h4A);
    @(posedge clk); #1;
    check("single_valid_e3", 32'(tx_valid), 32'd0);
    check("single_done", 32'(done), 32'd1);
    check("single_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("single_done_pulse", 32'(done), 32'd0);
    check("done_count_2", 32'(n_done), 32'(exp_done));

    // 3: four bytes at full rate, stray start mid-sweep
    start_sweep(8'h00, 8'h03, 1'b1);
    prev = 0;
    for (int b = 0; b < 4; b++) begin
      wait_valid(20);
      if (b > 0) check("byte_spacing", 32'(cyc - prev), 32'd3);
      prev = cyc;
      if (b == 1) start_sweep(8'h80, 8'h80, 1'b0);
      else begin
        @(posedge clk); #1;
      end
    end
    wait_idle(50, 1'b0);
    check("done_count_3", 32'(n_done), 32'(exp_done));

    // 4: backpressure holds the byte
    tx_ready = 1'b0;
    start_sweep(8'h20, 8'h21, 1'b1);
    wait_valid(20);
    repeat (5) begin
      check("hold_valid", 32'(tx_valid), 32'd1);
      check("hold_data", 32'(tx_data), 32'h7A);
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_idle(50, 1'b0);
    check("done_count_4", 32'(n_done), 32'(exp_done));

    // 5: wrap sweep, then full range
    start_sweep(8'hFE, 8'h01, 1'b1);
    wait_idle(50, 1'b0);
    rx0 = n_rx;
    start_sweep(8'h00, 8'hFF, 1'b1);
    wait_idle(1000, 1'b0);
    check("full_sweep_bytes", 32'(n_rx - rx0), 32'd256);
    check("done_count_5", 32'(n_done), 32'(exp_done));

    // random short sweeps under random backpressure
    repeat (6) begin
      f = 8'($urandom);
      start_sweep(f, f + 8'($urandom_range(0, 7)), 1'b1);
      wait_idle(300, 1'b1);
    end
    check("done_count_rand", 32'(n_done), 32'(exp_done));

    // 6: async reset during HOLD of the third byte
    tx_ready = 1'b1;
    start_sweep(8'h00, 8'h0F, 1'b1);
    cnt = 0;
    k = 0;
    while (cnt < 3 && k < 50) begin
      @(posedge clk); #1;
      if (tx_valid) cnt++;
      k++;
    end
    tx_ready = 1'b0;
    check("third_byte_seen", 32'(cnt), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(ram_addr), 32'd0);
    exp_q.delete();
    exp_done--;
    @(posedge clk); #1;
    check("abort_no_done", 32'(done), 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    tx_ready = 1'b1;
    start_sweep(8'h00, 8'h00, 1'b1);
    wait_idle(20, 1'b0);
    check("done_count_final", 32'(n_done), 32'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
